// File: rtl/rf_wport_arbiter_pkg.sv
// Shared widths and FSM encodings for the register-file write-port arbiter.
// The hazard unit decodes the same state encodings.
package rf_wport_arbiter_pkg;

    localparam int RF_REG_WIDTH    = 32;
    localparam int RF_ADDR_W       = 5;
    localparam int RF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_FORCE = 2'd2
    } arb_state_e;

endpackage : rf_wport_arbiter_pkg

// File: rtl/rf_wport_arbiter.sv
// Shares the register file's single write port between the WB stage and one
// buffered long-latency-unit result, forcing a one-cycle stall if the result starves.
module rf_wport_arbiter
    import rf_wport_arbiter_pkg::*;
#(
    parameter int REG_WIDTH    = RF_REG_WIDTH,
    parameter int ADDR_W       = RF_ADDR_W,
    parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wb_we,
    input  logic [ADDR_W-1:0]    wb_rd,
    input  logic [REG_WIDTH-1:0] WB_data,
    input  logic                 llu_valid,
    input  logic [ADDR_W-1:0]    llu_rd,
    input  logic [REG_WIDTH-1:0] llu_data,
    output logic                 llu_ready,
    output logic                 rf_we,
    output logic [ADDR_W-1:0]    rf_waddr,
    output logic [REG_WIDTH-1:0] rf_wdata,
    output logic                 pipe_stall,
    output logic                 pend_valid,
    output logic [ADDR_W-1:0]    pend_rd
);

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_LIMIT - 1);

    arb_state_e           state;
    logic [CNT_W-1:0]     cnt;
    logic [REG_WIDTH-1:0] pend_data;

    logic wb_act;
    logic accept;
    logic squash;

    // A stalled WB stage re-presents its write next cycle, so it is ignored now.
    assign wb_act    = wb_we && (wb_rd != '0) && !pipe_stall;
    assign llu_ready = !pend_valid;
    assign accept    = llu_valid && llu_ready && (llu_rd != '0);
    assign squash    = pend_valid && wb_act && (wb_rd == pend_rd);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (wb_act) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = WB_data;
        end else if (pend_valid) begin
            rf_we    = 1'b1;
            rf_waddr = pend_rd;
            rf_wdata = pend_data;
        end
    end

    // NOTE: state registers use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARB_IDLE;
            cnt        <= '0;
            pend_valid <= 1'b0;
            pend_rd    <= '0;
            pend_data  <= '0;
            pipe_stall <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        pend_valid <= 1'b1;
                        pend_rd    <= llu_rd;
                        pend_data  <= llu_data;
                        cnt        <= '0;
                        state      <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    if (squash || !wb_act) begin
                        // Either drained this cycle or overwritten by a younger WB write.
                        pend_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= ARB_IDLE;
                    end else if (cnt == CNT_LAST) begin
                        pipe_stall <= 1'b1;
                        state      <= ARB_FORCE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARB_FORCE: begin
                    pend_valid <= 1'b0;
                    pipe_stall <= 1'b0;
                    cnt        <= '0;
                    state      <= ARB_IDLE;
                end
                default: begin
                    pend_valid <= 1'b0;
                    pipe_stall <= 1'b0;
                    cnt        <= '0;
                    state      <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule : rf_wport_arbiter

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter: reset, idle drain, WB priority,
// starvation stall, WAW squash, x0 discard and backpressure.
module tb_rf_wport_arbiter;
    import rf_wport_arbiter_pkg::*;

    localparam int RW = RF_REG_WIDTH;
    localparam int AW = RF_ADDR_W;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wb_we;
    logic [AW-1:0] wb_rd;
    logic [RW-1:0] WB_data;
    logic          llu_valid;
    logic [AW-1:0] llu_rd;
    logic [RW-1:0] llu_data;
    logic          llu_ready;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [RW-1:0] rf_wdata;
    logic          pipe_stall;
    logic          pend_valid;
    logic [AW-1:0] pend_rd;

    int checks = 0;
    int errors = 0;

    rf_wport_arbiter #(
        .REG_WIDTH   (RW),
        .ADDR_W      (AW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .WB_data   (WB_data),
        .llu_valid (llu_valid),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .llu_ready (llu_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .pipe_stall(pipe_stall),
        .pend_valid(pend_valid),
        .pend_rd   (pend_rd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge; inputs are then driven for the new cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [AW-1:0] rd, input logic [RW-1:0] wd,
                         input logic lv, input logic [AW-1:0] lrd, input logic [RW-1:0] ld);
        wb_we     = we;
        wb_rd     = rd;
        WB_data   = wd;
        llu_valid = lv;
        llu_rd    = lrd;
        llu_data  = ld;
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [AW-1:0] a,
                              input logic [RW-1:0] d);
        check({tag, ".we"}, 32'(rf_we), 32'(we));
        check({tag, ".addr"}, 32'(rf_waddr), 32'(a));
        check({tag, ".data"}, 32'(rf_wdata), 32'(d));
    endtask

    initial begin
        // 1: reset with an LLU result offered
        reset_n = 1'b0;
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hBAD);
        @(posedge clk);
        #2;
        check_port("rst", 1'b0, '0, '0);
        check("rst.stall", 32'(pipe_stall), 32'd0);
        check("rst.pend", 32'(pend_valid), 32'd0);
        check("rst.ready", 32'(llu_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0, '0);

        // 2: idle drain
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'hDEAD);
        check("t2.c0.ready", 32'(llu_ready), 32'd1);
        check_port("t2.c0", 1'b0, '0, '0);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_port("t2.c1", 1'b1, 5'd7, 32'hDEAD);
        check("t2.c1.ready", 32'(llu_ready), 32'd0);
        check("t2.c1.pend_rd", 32'(pend_rd), 32'd7);
        next_cycle();
        check("t2.c2.pend", 32'(pend_valid), 32'd0);
        check_port("t2.c2", 1'b0, '0, '0);

        // 3: WB priority for two cycles, then pending drains
        drive(1'b0, '0, '0, 1'b1, 5'd5, 32'h55);
        next_cycle();
        drive(1'b1, 5'd3, 32'h31, 1'b0, '0, '0);
        check_port("t3.c1", 1'b1, 5'd3, 32'h31);
        check("t3.c1.stall", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b1, 5'd3, 32'h32, 1'b0, '0, '0);
        check_port("t3.c2", 1'b1, 5'd3, 32'h32);
        check("t3.c2.stall", 32'(pipe_stall), 32'd0);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_port("t3.c3", 1'b1, 5'd5, 32'h55);
        check("t3.c3.stall", 32'(pipe_stall), 32'd0);
        next_cycle();
        check("t3.c4.pend", 32'(pend_valid), 32'd0);

        // 4: starvation -> forced drain after four blocked cycles
        drive(1'b0, '0, '0, 1'b1, 5'd9, 32'h99);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            drive(1'b1, 5'd1, 32'(i), 1'b0, '0, '0);
            check_port($sformatf("t4.c%0d", i), 1'b1, 5'd1, 32'(i));
            check($sformatf("t4.c%0d.stall", i), 32'(pipe_stall), 32'd0);
            check($sformatf("t4.c%0d.pend", i), 32'(pend_valid), 32'd1);
        end
        next_cycle();
        drive(1'b1, 5'd1, 32'h5, 1'b0, '0, '0);
        check("t4.c5.stall", 32'(pipe_stall), 32'd1);
        check_port("t4.c5", 1'b1, 5'd9, 32'h99);
        next_cycle();
        drive(1'b1, 5'd1, 32'h6, 1'b0, '0, '0);
        check("t4.c6.stall", 32'(pipe_stall), 32'd0);
        check("t4.c6.pend", 32'(pend_valid), 32'd0);
        check_port("t4.c6", 1'b1, 5'd1, 32'h6);

        // 5: WAW squash
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 5'd12, 32'h11);
        next_cycle();
        drive(1'b1, 5'd12, 32'h22, 1'b0, '0, '0);
        check_port("t5.c1", 1'b1, 5'd12, 32'h22);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("t5.c2.pend", 32'(pend_valid), 32'd0);
        check_port("t5.c2", 1'b0, '0, '0);

        // 6a: LLU result to x0 is accepted and discarded
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h77);
        check("t6.x0.ready", 32'(llu_ready), 32'd1);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check("t6.x0.pend", 32'(pend_valid), 32'd0);
        check_port("t6.x0", 1'b0, '0, '0);

        // 6b: backpressure while a result is pending
        drive(1'b0, '0, '0, 1'b1, 5'd4, 32'h44);
        next_cycle();
        drive(1'b1, 5'd2, 32'h20, 1'b1, 5'd6, 32'h66);
        check("t6.c1.ready", 32'(llu_ready), 32'd0);
        check_port("t6.c1", 1'b1, 5'd2, 32'h20);
        next_cycle();
        drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h66);
        check("t6.c2.ready", 32'(llu_ready), 32'd0);
        check_port("t6.c2", 1'b1, 5'd4, 32'h44);
        next_cycle();
        check("t6.c3.ready", 32'(llu_ready), 32'd1);
        check_port("t6.c3", 1'b0, '0, '0);
        next_cycle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_port("t6.c4", 1'b1, 5'd6, 32'h66);
        next_cycle();

        // Reset while waiting drops the pending result
        drive(1'b0, '0, '0, 1'b1, 5'd8, 32'h88);
        next_cycle();
        drive(1'b1, 5'd2, 32'h21, 1'b0, '0, '0);
        check("rst2.pend_before", 32'(pend_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst2.pend", 32'(pend_valid), 32'd0);
        check("rst2.pend_rd", 32'(pend_rd), 32'd0);
        drive(1'b0, '0, '0, 1'b0, '0, '0);
        check_port("rst2", 1'b0, '0, '0);
        reset_n = 1'b1;
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_rf_wport_arbiter
